ftoi_pipe: RTL and testbench
============================

Name: ftoi_pipe

Overview:
- Pipelined IEEE-754 single-precision to 32-bit signed integer converter for the FPU.
- Inverse of the integer-to-float unit.
- Accepts one operand per cycle through a valid/ready handshake and delivers the result 2 cycles after acceptance.
- Supports round-to-nearest (ties away from zero) and truncation, with saturation and status flags for the core's exception logic.

Parameters:
- ROUND_DEFAULT, 1'b0, rounding mode when rm_override=0 (0 = nearest ties-away, 1 = truncate toward zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept the operand this cycle.
- x  in  32  float operand {sign, exp[7:0], frac[22:0]}.
- rm_override  in  1  1 = use rm_in instead of ROUND_DEFAULT.
- rm_in  in  1  per-operation rounding mode, same encoding as ROUND_DEFAULT.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  32  two's-complement integer result.
- inexact  out  1  the discarded fraction was nonzero (and the result did not saturate).
- invalid  out  1  NaN, infinity, or out of range; the result is saturated.

Behaviour:
- Reset: asserting rst clears all stage-valid bits immediately (asynchronously); out_valid=0, y=0, inexact=0, invalid=0. Data registers need not reset. An operation in flight when reset hits is dropped with no output.
- Pipeline: stage S1 registers the operand; stage S2 is the output register.
  - Single enable: en = !out_valid | out_ready.
  - in_ready = en (combinational from out_valid and out_ready).
  - When en=1, both stages advance together. S1.valid <= in_valid; S2 <= S1. Bubbles are not compressed.
  - When en=0, everything holds. y and the flags must stay stable while out_valid=1 and out_ready=0.
  - Latency: an operand accepted in cycle t produces out_valid in cycle t+2 if out_ready stays high. Throughput is 1 per cycle.
- S1 (registered from x): sign s, e = x[30:23], mant = {1, x[22:0]}.
  - Shift mant into a 32-bit integer part plus guard bit g and sticky bit st, with shift amount e-150.
  - Class flags: zero/denormal (e==0), NaN/inf (e==255), big (e>=158), tiny (e<126).
- S2 (registered from S1):
  - Round: magnitude = int + (rm==nearest & g). Truncate ignores g and st.
  - inexact = g | st (for tiny, inexact = x nonzero).
  - Apply the sign by two's-complement negation.
- Boundary rules (in priority order):
  - NaN (e=255, frac!=0): y=0x7FFFFFFF, invalid=1, inexact=0.
  - +inf: y=0x7FFFFFFF, invalid=1. −inf: y=0x80000000, invalid=1.
  - x==0xCF000000 (−2^31): y=0x80000000, invalid=0, inexact=0.
  - Any other big operand: y=0x7FFFFFFF if s=0, else 0x80000000; invalid=1, inexact=0.
  - ±0 and denormals: y=0. inexact=1 for denormals only.
  - tiny (|x|<0.5): y=0 in both modes. e==126 (0.5 ≤ |x| < 1): y=±1 under nearest, 0 under truncate.
  - −0 gives y=0x00000000.
  - e≥150: exact, no fractional bits.
- Rounding mode is sampled with x at acceptance and travels with the operand.

Test Plan:
- Nearest, back-to-back stream 0x3FC00000 (1.5), 0xC0200000 (−2.5), 0x3F000000 (0.5), 0x3EFAE148 (0.49), with out_ready=1 → y = 0x00000002, 0xFFFFFFFD, 0x00000001, 0x00000000 on 4 consecutive cycles, first at t+2; inexact=1 for all.
- Truncate via rm_override=1, rm_in=1, same stream → y = 0x00000001, 0xFFFFFFFE, 0x00000000, 0x00000000.
- Range limits:
  - 0x4EFFFFFF → 0x7FFFFF80, flags 0.
  - 0x4F000000 → 0x7FFFFFFF, invalid=1.
  - 0xCF000000 → 0x80000000, invalid=0.
  - 0x7FC00000 → 0x7FFFFFFF, invalid=1.
  - 0xFF800000 → 0x80000000, invalid=1.
  - 0x00000001 → 0, inexact=1.
- Backpressure: hold out_ready=0 for 5 cycles with 3 operands offered → in_ready=0 once both stages are full; y is stable; no loss or duplication; results emerge in order after out_ready=1.
- Reset mid-operation: accept 0x42F60000 (123.0), assert rst the next cycle → out_valid=0 immediately; after release no result appears; a new operand 0xC2F60000 → 0xFFFFFF85 at t+2.

Source files
------------

// File: rtl/ftoi_pipe.sv
// ftoi_pipe
// ---------------------------------------------------------------------------
// Pipelined IEEE-754 single-precision float to 32-bit signed integer
// converter. This is the inverse of the integer-to-float unit. One operand
// is accepted per cycle, and each result appears two cycles after the
// operand is accepted.
//
// Rounding modes
//   0 = round to nearest, ties away from zero
//   1 = truncate toward zero
// The rounding mode is captured together with the operand, so a mode
// change never affects operations that are already in flight.
//
// Out-of-range inputs saturate, and status flags are raised for the core's
// exception logic.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-high reset; drops everything in flight
//   in_valid     operand valid
//   in_ready     converter can accept the operand this cycle
//   x            float operand {sign, exp[7:0], frac[22:0]}
//   rm_override  1 = use rm_in instead of ROUND_DEFAULT
//   rm_in        per-operation rounding mode
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   y            two's-complement integer result
//   inexact      the discarded fraction was nonzero (and no saturation)
//   invalid      NaN, infinity or out of range; y is saturated
// ---------------------------------------------------------------------------
module ftoi_pipe #(
    parameter logic ROUND_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        rm_override,
    input  logic        rm_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        inexact,
    output logic        invalid
);

    // Both stages share one enable. The pipeline only stalls when the
    // output register holds a result that the consumer has not taken yet.
    // Bubbles move through the pipeline like data and are not squeezed out.
    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1 input decode and alignment (combinational, from x)
    // ------------------------------------------------------------------
    logic        sgn_c;
    logic [7:0]  exp_c;
    logic [22:0] frac_c;
    logic [23:0] mant_c;
    logic        rm_c;

    assign sgn_c  = x[31];
    assign exp_c  = x[30:23];
    assign frac_c = x[22:0];
    assign mant_c = {1'b1, frac_c};
    assign rm_c   = rm_override ? rm_in : ROUND_DEFAULT;

    // The value is mant * 2^(exp-150).
    //
    // Left shift (exp >= 150): only exponents 150..157 reach the general
    // path, because 158 and above are caught as "big". That means only the
    // low three bits of (exp-150) matter. Since 150 mod 8 = 6, those bits
    // are exp[2:0]-6.
    //
    // Right shift (exp < 150): the mantissa is placed above a 25-bit
    // field, which leaves room for the guard bit and the sticky bits.
    // A right shift of 24 (exp == 126) still leaves the hidden one in the
    // guard position. Anything smaller is "tiny" and has its own handling,
    // so the shift is clamped to 25.
    logic [2:0]  lsh_c;
    logic [7:0]  rsh_c;
    logic [4:0]  rsh_clip_c;
    logic [48:0] ext_c;
    logic [31:0] int_c;
    logic        g_c;
    logic        st_c;

    assign lsh_c      = exp_c[2:0] - 3'd6;
    assign rsh_c      = 8'd150 - exp_c;
    assign rsh_clip_c = (rsh_c > 8'd25) ? 5'd25 : rsh_c[4:0];
    assign ext_c      = {mant_c, 25'd0} >> rsh_clip_c;

    // Pick the integer part, guard bit and sticky bit. When the shift is
    // to the left, the result is exact, so no fraction bits are discarded.
    always_comb begin
        int_c = 32'd0;
        g_c   = 1'b0;
        st_c  = 1'b0;
        if (exp_c >= 8'd150) begin
            int_c = {8'd0, mant_c} << lsh_c;
        end else begin
            int_c = {8'd0, ext_c[48:25]};
            g_c   = ext_c[24];
            st_c  = |ext_c[23:0];
        end
    end

    // Operand classes, evaluated in stage 1 so that stage 2 only has to
    // select the result.
    logic zero_c, denorm_c, nan_c, inf_c, big_c, tiny_c, negmin_c;

    assign zero_c   = (exp_c == 8'd0);
    assign denorm_c = (exp_c == 8'd0) && (frac_c != 23'd0);
    assign nan_c    = (exp_c == 8'hFF) && (frac_c != 23'd0);
    assign inf_c    = (exp_c == 8'hFF) && (frac_c == 23'd0);
    assign big_c    = (exp_c >= 8'd158);
    assign tiny_c   = (exp_c < 8'd126);
    assign negmin_c = (x == 32'hCF00_0000);

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic        s1_valid;
    logic        s1_sign;
    logic        s1_rm;
    logic [31:0] s1_int;
    logic        s1_g;
    logic        s1_st;
    logic        s1_zero;
    logic        s1_denorm;
    logic        s1_nan;
    logic        s1_inf;
    logic        s1_big;
    logic        s1_tiny;
    logic        s1_negmin;

    // The stage-1 valid bit is the only stage-1 state that reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 data loads on every enabled cycle. These registers are not
    // reset: they only matter when the valid bit that travels with them
    // is set.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign   <= sgn_c;
            s1_rm     <= rm_c;
            s1_int    <= int_c;
            s1_g      <= g_c;
            s1_st     <= st_c;
            s1_zero   <= zero_c;
            s1_denorm <= denorm_c;
            s1_nan    <= nan_c;
            s1_inf    <= inf_c;
            s1_big    <= big_c;
            s1_tiny   <= tiny_c;
            s1_negmin <= negmin_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 rounding, sign and boundary selection (combinational)
    // ------------------------------------------------------------------
    logic [31:0] mag_c;
    logic [31:0] signed_c;
    logic [31:0] y_c;
    logic        inexact_c;
    logic        invalid_c;

    // Rounding works on the magnitude. Adding the guard bit therefore
    // rounds ties away from zero for either sign. The largest magnitude
    // on this path is below 2^31, so the add cannot overflow.
    assign mag_c    = s1_int + {31'd0, (!s1_rm && s1_g)};
    assign signed_c = s1_sign ? (32'd0 - mag_c) : mag_c;

    // The special cases are checked in priority order. NaN and infinity
    // are tested before "big", because exponent 255 is also >= 158.
    // -2^31 is the one big value that is exactly representable.
    always_comb begin
        y_c       = signed_c;
        inexact_c = s1_g || s1_st;
        invalid_c = 1'b0;
        if (s1_nan) begin
            y_c       = 32'h7FFF_FFFF;
            inexact_c = 1'b0;
            invalid_c = 1'b1;
        end else if (s1_inf) begin
            y_c       = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            inexact_c = 1'b0;
            invalid_c = 1'b1;
        end else if (s1_negmin) begin
            y_c       = 32'h8000_0000;
            inexact_c = 1'b0;
        end else if (s1_big) begin
            y_c       = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            inexact_c = 1'b0;
            invalid_c = 1'b1;
        end else if (s1_zero) begin
            y_c       = 32'd0;
            inexact_c = s1_denorm;
        end else if (s1_tiny) begin
            // A normal number below 0.5 rounds to zero in both modes,
            // and because it is nonzero the result is always inexact.
            y_c       = 32'd0;
            inexact_c = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 output register
    // ------------------------------------------------------------------
    // The outputs are reset so the core sees clean zeros during reset.
    // While the stage is stalled they hold, so y and the flags stay stable
    // until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
            inexact   <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            y         <= y_c;
            inexact   <= inexact_c;
            invalid   <= invalid_c;
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe
// ---------------------------------------------------------------------------
// Self-checking bench for ftoi_pipe.
//
// A table of operands with hand-computed results is streamed through the
// converter. Every accepted operand pushes its expected result onto a
// scoreboard queue. A monitor pops an entry and compares it whenever the
// DUT hands off a result.
//
// Hand-written sequences cover backpressure, a reset with an operation in
// flight, and an asynchronous reset while the output stage is full.
// ---------------------------------------------------------------------------
module tb_ftoi_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        rm_override;
    logic        rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        inexact;
    logic        invalid;

    ftoi_pipe #(.ROUND_DEFAULT(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .rm_override (rm_override),
        .rm_in       (rm_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .inexact     (inexact),
        .invalid     (invalid)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] xv;
        logic        rmo;
        logic        rm;
        logic [31:0] ey;
        logic        ei;
        logic        ev;
    } vec_t;

    typedef struct {
        logic [31:0] ey;
        logic        ei;
        logic        ev;
        int          acc;
        int          id;
    } sb_t;

    localparam int NV = 24;
    vec_t vecs [0:NV-1];
    sb_t  sbQ [$];

    int          vectors    = 0;
    int          miscompares = 0;
    int          cycle      = 0;
    bit          latChk     = 0;
    bit          streamDone = 0;
    logic [31:0] drvY;
    logic        drvInx;
    logic        drvInv;
    int          drvId;

    always @(posedge clk) cycle <= cycle + 1;

    // One comparison: counts it and reports it when it does not match.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one operand at posedge+1 and holds it until it is accepted.
    // The task returns at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] xv, input logic rmo, input logic rm,
                                 input logic [31:0] ey, input logic ei, input logic ev,
                                 input int id);
        bit accepted;
        accepted    = 1'b0;
        x           = xv;
        rm_override = rmo;
        rm_in       = rm;
        drvY        = ey;
        drvInx      = ei;
        drvInv      = ev;
        drvId       = id;
        in_valid    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout[%0d]: in_ready stayed 0, expected 1", id);
        end
    endtask

    // Waits, with a bound, for every pending result to come out.
    task automatic drainQueue(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sbQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_pending", sbQ.size(), 0);
    endtask

    // Scoreboard monitor. It samples on the falling edge; what it sees
    // there is what the next rising edge will act on.
    logic [31:0] heldY;
    logic        heldI;
    logic        heldV;
    bit          holdArmed = 0;

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            holdArmed = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: y=%h appeared, expected no result", y);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput($sformatf("y[%0d]", e.id), y, e.ey);
                    checkOutput($sformatf("inexact[%0d]", e.id), {31'd0, inexact}, {31'd0, e.ei});
                    checkOutput($sformatf("invalid[%0d]", e.id), {31'd0, invalid}, {31'd0, e.ev});
                    if (latChk)
                        checkOutput($sformatf("latency[%0d]", e.id), cycle - e.acc, 2);
                end
            end
            if (out_valid && !out_ready) begin
                if (holdArmed) begin
                    checkOutput("stall_y_stable", y, heldY);
                    checkOutput("stall_flags_stable", {30'd0, inexact, invalid}, {30'd0, heldI, heldV});
                end
                heldY     = y;
                heldI     = inexact;
                heldV     = invalid;
                holdArmed = 1;
            end else begin
                holdArmed = 0;
            end
            if (in_valid && in_ready)
                sbQ.push_back('{drvY, drvInx, drvInv, cycle, drvId});
        end
    end

    initial begin
        // {x, rm_override, rm_in, expected y, inexact, invalid}
        vecs[0]  = '{32'h3FC00000, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0}; // 1.5 nearest
        vecs[1]  = '{32'hC0200000, 1'b0, 1'b0, 32'hFFFFFFFD, 1'b1, 1'b0}; // -2.5 nearest
        vecs[2]  = '{32'h3F000000, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0}; // 0.5 nearest
        vecs[3]  = '{32'h3EFAE148, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}; // 0.49
        vecs[4]  = '{32'h3FC00000, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0}; // 1.5 trunc
        vecs[5]  = '{32'hC0200000, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0}; // -2.5 trunc
        vecs[6]  = '{32'h3F000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0}; // 0.5 trunc
        vecs[7]  = '{32'h3EFAE148, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0}; // 0.49 trunc
        vecs[8]  = '{32'h4EFFFFFF, 1'b0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0}; // largest in range
        vecs[9]  = '{32'h4F000000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1}; // 2^31
        vecs[10] = '{32'hCF000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0}; // -2^31 exact
        vecs[11] = '{32'h7FC00000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1}; // NaN
        vecs[12] = '{32'hFF800000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1}; // -inf
        vecs[13] = '{32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}; // denormal
        vecs[14] = '{32'h7F800000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1}; // +inf
        vecs[15] = '{32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0}; // -0
        vecs[16] = '{32'hCF000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1}; // below -2^31
        vecs[17] = '{32'hBF000000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}; // -0.5 nearest
        vecs[18] = '{32'h4B000001, 1'b0, 1'b0, 32'h00800001, 1'b0, 1'b0}; // e=150 exact
        vecs[19] = '{32'h42F60000, 1'b0, 1'b0, 32'h0000007B, 1'b0, 1'b0}; // 123.0
        vecs[20] = '{32'h3FFFFFFF, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0}; // ~2 nearest via override
        vecs[21] = '{32'h3FFFFFFF, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0}; // ~2 trunc
        vecs[22] = '{32'hC0600000, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b1, 1'b0}; // -3.5 trunc
        vecs[23] = '{32'hBF400000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}; // -0.75 nearest

        rst         = 1'b1;
        in_valid    = 1'b0;
        x           = 32'd0;
        rm_override = 1'b0;
        rm_in       = 1'b0;
        out_ready   = 1'b0;
        drvY        = 32'd0;
        drvInx      = 1'b0;
        drvInv      = 1'b0;
        drvId       = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_y", y, 32'd0);
        checkOutput("reset_inexact", {31'd0, inexact}, 32'd0);
        checkOutput("reset_invalid", {31'd0, invalid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream of the whole table with latency checks
        $display("[TB] table stream, out_ready held high");
        latChk = 1;
        for (int i = 0; i < NV; i++)
            applyStimulus(vecs[i].xv, vecs[i].rmo, vecs[i].rm, vecs[i].ey, vecs[i].ei, vecs[i].ev, i);
        in_valid = 1'b0;
        drainQueue(20);
        latChk = 0;

        // Backpressure: three operands offered while the consumer stalls
        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(32'h40400000, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 100);
                applyStimulus(32'hC0600000, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 101);
                applyStimulus(32'h3F000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 102);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                checkOutput("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                checkOutput("bp_out_valid_full", {31'd0, out_valid}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drainQueue(20);

        // Table again with random consumer stalls
        $display("[TB] table stream, random out_ready");
        streamDone = 0;
        fork
            begin
                for (int i = 0; i < NV; i++)
                    applyStimulus(vecs[i].xv, vecs[i].rmo, vecs[i].rm, vecs[i].ey, vecs[i].ei, vecs[i].ev, 300 + i);
                in_valid   = 1'b0;
                streamDone = 1;
            end
            begin
                while (!streamDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drainQueue(40);

        // Reset one cycle after accepting an operand
        $display("[TB] reset with operation in flight");
        applyStimulus(32'h42F60000, 1'b0, 1'b0, 32'h0000007B, 1'b0, 1'b0, 200);
        in_valid = 1'b0;
        rst      = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_out_valid_held", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        latChk = 1;
        applyStimulus(32'hC2F60000, 1'b0, 1'b0, 32'hFFFFFF85, 1'b0, 1'b0, 201);
        in_valid = 1'b0;
        drainQueue(20);
        latChk = 0;

        // Asynchronous reset while a stalled result sits in the output stage
        $display("[TB] async reset with full output stage");
        out_ready = 1'b0;
        applyStimulus(32'h42F60000, 1'b0, 1'b0, 32'h0000007B, 1'b0, 1'b0, 202);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("stalled_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stalled_y", y, 32'h0000007B);
        #2;
        rst = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_reset_y", y, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        drainQueue(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
